// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory bank and its controller.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    RESP
  } imem_state_t;

  localparam int IMEM_WORDS = 16;
  localparam int IMEM_AW    = 4;
  localparam int IMEM_DW    = 32;
  localparam int MACRO_DW   = 2;
  localparam int MACROS     = IMEM_DW / MACRO_DW;

endpackage

// File: rtl/imem_sram_bank.sv
// 32-bit x 16-word bank built from 16 two-bit macros; macro k owns bits [2k+1:2k].
// Latency: inherits the macro timing; no backpressure.
// Command inputs are broadcast to every macro.
module imem_sram_bank
  import imem_pkg::*;
(
  input  logic               clk0,
  input  logic               csb,
  input  logic               web,
  input  logic [IMEM_AW-1:0] addr,
  input  logic [IMEM_DW-1:0] din,
  output logic [IMEM_DW-1:0] dout
);

  for (genvar k = 0; k < MACROS; k++) begin : g_macro
    sram_2_16_sky130A u_macro (
      .clk0  (clk0),
      .csb0  (csb),
      .web0  (web),
      .addr0 (addr),
      .din0  (din[MACRO_DW*k +: MACRO_DW]),
      .dout0 (dout[MACRO_DW*k +: MACRO_DW])
    );
  end

endmodule

// File: rtl/sram_2_16_sky130A.sv
// Behavioural 2-bit x 16-word single-port macro: command registered on posedge,
// write or read performed on the following negedge.
// Latency: read data valid after the negedge following the issue posedge; no backpressure.
module sram_2_16_sky130A (
  input  logic       clk0,
  input  logic       csb0,
  input  logic       web0,
  input  logic [3:0] addr0,
  input  logic [1:0] din0,
  output logic [1:0] dout0
);

  logic       csb0_reg;
  logic       web0_reg;
  logic [3:0] addr0_reg;
  logic [1:0] din0_reg;
  logic [1:0] mem [16];

  always_ff @(posedge clk0) begin
    csb0_reg  <= csb0;
    web0_reg  <= web0;
    addr0_reg <= addr0;
    din0_reg  <= din0;
  end

  always_ff @(negedge clk0) begin
    if (!csb0_reg && !web0_reg) mem[addr0_reg] <= din0_reg;
    if (!csb0_reg && web0_reg)  dout0 <= mem[addr0_reg];
  end

endmodule

// File: rtl/imem_sram_ctrl.sv
// Fetch/program-load controller sequencing the registered SRAM bank interface.
// Latency: grant cycle + 3 to rsp_valid (+1 for an error fetch); one load per 2 cycles.
// Backpressure: RESP holds rsp_* until rsp_ready; no new grant until the response is taken.
module imem_sram_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_WORDS  = IMEM_WORDS,
  parameter int          ADDR_WIDTH = IMEM_AW,
  parameter int          DATA_WIDTH = IMEM_DW
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic                  rsp_err,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  imem_state_t           state, state_nxt;
  logic                  csb_nxt, web_nxt, valid_nxt, err_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] din_nxt, instr_nxt;
  logic [31:0]           fetch_off;
  logic                  fetch_bad;
  logic [ADDR_WIDTH-1:0] fetch_idx;

  assign fetch_off = fetch_addr - BASE_ADDR;
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr < BASE_ADDR) ||
                     (fetch_off >= 32'(NUM_WORDS * 4));
  assign fetch_idx = fetch_off[ADDR_WIDTH+1:2];

  // Handshakes are gated by reset so nothing is accepted while the flops are held.
  assign load_ready = rst0_n && (state == IDLE);
  assign fetch_gnt  = load_ready && !load_valid;

  always_comb begin
    state_nxt = state;
    csb_nxt   = 1'b1;
    web_nxt   = 1'b1;
    addr_nxt  = sram_addr;
    din_nxt   = sram_din;
    valid_nxt = rsp_valid;
    instr_nxt = rsp_instr;
    err_nxt   = rsp_err;
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nxt = WR_ISSUE;
          csb_nxt   = 1'b0;
          web_nxt   = 1'b0;
          addr_nxt  = load_addr;
          din_nxt   = load_data;
        end else if (fetch_req) begin
          if (fetch_bad) begin
            state_nxt = RESP;
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
            instr_nxt = '0;
          end else begin
            state_nxt = RD_ISSUE;
            csb_nxt   = 1'b0;
            addr_nxt  = fetch_idx;
          end
        end
      end
      RD_ISSUE:   state_nxt = RD_CAPTURE;
      // Macro drove dout at the mid-cycle negedge; this edge is inside the valid window.
      RD_CAPTURE: begin
        state_nxt = RESP;
        valid_nxt = 1'b1;
        err_nxt   = 1'b0;
        instr_nxt = sram_dout;
      end
      WR_ISSUE:   state_nxt = IDLE;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state     <= IDLE;
      sram_csb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_addr <= '0;
      sram_din  <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sram_csb  <= csb_nxt;
      sram_web  <= web_nxt;
      sram_addr <= addr_nxt;
      sram_din  <= din_nxt;
      rsp_valid <= valid_nxt;
      rsp_instr <= instr_nxt;
      rsp_err   <= err_nxt;
    end
  end

endmodule

// File: doc/imem_sram_ctrl.md
Name: imem_sram_ctrl

Overview:
- Instruction-memory controller between the RISC-V fetch stage and a 32-bit × 16-word bank.
- The bank is 16 sram_2_16_sky130A macros side by side, each supplying 2 bits.
- Accepts fetch requests (byte address) and a program-load write port.
- Sequences the macros' registered csb/web/addr/din interface, captures dout in the safe window, and returns instruction words over a valid/ready response channel.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- NUM_WORDS, 16, instruction words in the bank.
- ADDR_WIDTH, 4, SRAM word-address width.
- DATA_WIDTH, 32, instruction width (16 macros × 2 bits).

Ports:
- clk0, in, 1, clock, shared with the SRAM macros.
- rst0_n, in, 1, asynchronous active-low reset.
- fetch_req, in, 1, fetch request valid.
- fetch_addr, in, 32, fetch byte address.
- fetch_gnt, out, 1, request accepted this cycle.
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, consumer accepts the response.
- rsp_instr, out, 32, instruction word.
- rsp_err, out, 1, misaligned or out-of-range fetch.
- load_valid, in, 1, program-load write valid.
- load_addr, in, 4, word index to write.
- load_data, in, 32, word to write.
- load_ready, out, 1, load accepted this cycle.
- sram_csb, out, 1, active-low chip select to all macros.
- sram_web, out, 1, active-low write enable.
- sram_addr, out, 4, word address.
- sram_din, out, 32, write data; bits [2k+1:2k] go to macro k.
- sram_dout, in, 32, read data, same slicing.

Behaviour:
- Clocking/reset: one clock clk0; reset rst0_n asynchronous active-low.
- Reset values: state=IDLE, sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, rsp_valid=0, rsp_instr=0, rsp_err=0.
- fetch_gnt and load_ready are combinational and are 0 during reset.
- All sram_* outputs come directly from flops; no combinational path from inputs to sram_*.
- States:
  - IDLE: waiting for a request.
  - RD_ISSUE: csb=0, web=1 held through one posedge; the SRAM registers the command there.
  - RD_CAPTURE: csb=1; sram_dout is sampled into rsp_instr at the end of this cycle. This is the posedge after the macro's negedge read + DELAY and before its T_HOLD x-out.
  - WR_ISSUE: csb=0, web=0; the macro writes at the following negedge.
  - RESP: rsp_valid=1; hold rsp_instr/rsp_err stable until rsp_ready.
- Arbitration in IDLE: load has priority.
  - load_ready = (state==IDLE).
  - fetch_gnt = (state==IDLE) && !load_valid.
- Load path: IDLE + load_valid → WR_ISSUE with addr=load_addr, din=load_data, then → IDLE. One load per 2 cycles.
- Fetch decode: offset = fetch_addr − BASE_ADDR.
  - Error if fetch_addr[1:0]!=0, fetch_addr<BASE_ADDR, or offset ≥ NUM_WORDS*4.
  - Otherwise word index = offset[5:2].
- Error fetch: IDLE → RESP directly with rsp_err=1, rsp_instr=0. No SRAM access; csb stays 1.
- Normal fetch: IDLE → RD_ISSUE → RD_CAPTURE → RESP.
  - Grant at edge A; rsp_valid high after edge A+3.
  - Sustained throughput: one instruction per 4 cycles with rsp_ready=1.
- RESP exit:
  - On rsp_valid && rsp_ready → IDLE; rsp_valid drops next cycle.
  - The next request is not granted in the same cycle as response acceptance.
- Read-after-write: a fetch granted the cycle after WR_ISSUE returns the newly written word, because the macro write completes at the negedge before the read issue.
- Reset mid-access: all state clears immediately and csb goes to 1. Any SRAM read in flight is discarded; no response is produced.
- Timing constraint: DELAY is less than half the clk0 period (signed off in STA); RD_CAPTURE sampling depends on it.
- Never assert csb=0 for two consecutive cycles.
- X-propagation: rsp_instr only ever loads sram_dout in RD_CAPTURE; X on sram_dout at other times must not reach any flop.

Decomposition:
- Package imem_pkg holds:
  - state enum imem_state_t {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP};
  - constants IMEM_WORDS=16, IMEM_AW=4, IMEM_DW=32, MACRO_DW=2, MACROS=IMEM_DW/MACRO_DW.
- The controller is a single module.
- The 16-macro slicing lives in the sibling imem_sram_bank, which instantiates sram_2_16_sky130A ×16.
- Benches instantiate imem_sram_bank with the behavioural macro (VERBOSE=0).

Test Plan:
- Reset then idle 5 cycles → sram_csb=1, rsp_valid=0, fetch_gnt=1, load_ready=1.
- Load word 3 = 32'hDEADBEEF, then fetch 0x0C with rsp_ready=1 → fetch_gnt then rsp_valid 3 cycles later with rsp_instr=32'hDEADBEEF, rsp_err=0, csb low exactly 1 cycle.
- Load all 16 words with value 0x1000_0000+i, then fetch 0x00..0x3C back-to-back → each response correct, one response per 4 cycles, no X on rsp_instr.
- Fetch 0x02 and 0x40 → rsp_err=1, rsp_instr=0 after 1 cycle, sram_csb never drops.
- Hold rsp_ready=0 for 5 cycles during RESP → rsp_valid/rsp_instr stable, fetch_gnt=0, load_ready=0; accept → IDLE.
- load_valid and fetch_req asserted together → load granted first (WR_ISSUE), then fetch granted and returns the new data.
- Assert rst0_n=0 during RD_CAPTURE → csb=1 and rsp_valid=0 immediately; no response after release; the next fetch returns correct data.
